// File: rtl/pkt_classifier_linear_if.sv
// Rule-write, packet and result streams of the linear packet classifier.
// Header layout (MSB..LSB): src_ip, dst_ip, src_port, dst_port, proto.
interface pkt_classifier_linear_if #(
  parameter int IDX_W = 4
);
  logic             rule_wr_en;
  logic             rule_wr_ready;
  logic [IDX_W-1:0] rule_wr_idx;
  logic [103:0]     rule_wr_lo;
  logic [103:0]     rule_wr_hi;
  logic             rule_wr_enable;
  logic             pkt_valid;
  logic             pkt_ready;
  logic [103:0]     pkt_data;
  logic             res_valid;
  logic             res_ready;
  logic             res_hit;
  logic [IDX_W-1:0] res_rule_idx;

  modport master (
    output rule_wr_en, rule_wr_idx, rule_wr_lo, rule_wr_hi, rule_wr_enable,
    output pkt_valid, pkt_data, res_ready,
    input  rule_wr_ready, pkt_ready, res_valid, res_hit, res_rule_idx
  );

  modport slave (
    input  rule_wr_en, rule_wr_idx, rule_wr_lo, rule_wr_hi, rule_wr_enable,
    input  pkt_valid, pkt_data, res_ready,
    output rule_wr_ready, pkt_ready, res_valid, res_hit, res_rule_idx
  );
endinterface

// File: rtl/pkt_classifier_linear.sv
// Linear-scan 5-tuple classifier: one rule per cycle, lowest matching index wins.
// Optional hit/miss counters are built when CLASSIFIER_STATS_EN is defined.
module pkt_classifier_linear #(
  parameter int NUM_RULES = 16,
  parameter int IDX_W     = $clog2(NUM_RULES)
) (
  input  logic                   clk,
  input  logic                   rst,
  pkt_classifier_linear_if.slave io,
  output logic                   busy,
  output logic [31:0]            stat_hits,
  output logic [31:0]            stat_misses
);
  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t               state;
  logic [103:0]         hdr_q;
  logic [IDX_W-1:0]     idx_q;
  logic                 hit_q;
  logic [IDX_W-1:0]     res_idx_q;
  logic [NUM_RULES-1:0] en_q;
  logic [103:0]         lo_q [NUM_RULES];
  logic [103:0]         hi_q [NUM_RULES];
  logic [103:0]         cur_lo, cur_hi;
  logic [4:0]           fld_ok;
  logic                 match;
  logic                 wr_fire;

  function automatic logic in_rng(input logic [31:0] v, input logic [31:0] lo,
                                  input logic [31:0] hi);
    return (lo <= v) && (v <= hi);
  endfunction

  assign io.pkt_ready     = (state == IDLE);
  assign io.rule_wr_ready = (state == IDLE);
  assign io.res_valid     = (state == DONE);
  assign io.res_hit       = hit_q;
  assign io.res_rule_idx  = res_idx_q;
  assign busy             = (state != IDLE);
  assign wr_fire          = io.rule_wr_en && (state == IDLE);

  // An inverted range (lo > hi) fails in_rng for every value, so it never matches.
  always_comb begin
    cur_lo    = lo_q[idx_q];
    cur_hi    = hi_q[idx_q];
    fld_ok[4] = in_rng(hdr_q[103:72], cur_lo[103:72], cur_hi[103:72]);
    fld_ok[3] = in_rng(hdr_q[71:40],  cur_lo[71:40],  cur_hi[71:40]);
    fld_ok[2] = in_rng({16'd0, hdr_q[39:24]}, {16'd0, cur_lo[39:24]}, {16'd0, cur_hi[39:24]});
    fld_ok[1] = in_rng({16'd0, hdr_q[23:8]},  {16'd0, cur_lo[23:8]},  {16'd0, cur_hi[23:8]});
    fld_ok[0] = in_rng({24'd0, hdr_q[7:0]},   {24'd0, cur_lo[7:0]},   {24'd0, cur_hi[7:0]});
    match     = en_q[idx_q] && (&fld_ok);
  end

  // Range bounds carry no reset; the enable bits alone make a cleared table.
  always_ff @(posedge clk) begin
    if (wr_fire) begin
      lo_q[io.rule_wr_idx] <= io.rule_wr_lo;
      hi_q[io.rule_wr_idx] <= io.rule_wr_hi;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      hdr_q     <= '0;
      idx_q     <= '0;
      hit_q     <= 1'b0;
      res_idx_q <= '0;
      en_q      <= '0;
    end else begin
      if (wr_fire) en_q[io.rule_wr_idx] <= io.rule_wr_enable;
      case (state)
        IDLE: if (io.pkt_valid) begin
          hdr_q <= io.pkt_data;
          idx_q <= '0;
          state <= SCAN;
        end
        SCAN: if (match) begin
          hit_q     <= 1'b1;
          res_idx_q <= idx_q;
          state     <= DONE;
        end else if (idx_q == IDX_W'(NUM_RULES - 1)) begin
          hit_q     <= 1'b0;
          res_idx_q <= '0;
          state     <= DONE;
        end else begin
          idx_q <= idx_q + IDX_W'(1);
        end
        DONE: if (io.res_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef CLASSIFIER_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_hits   <= '0;
      stat_misses <= '0;
    end else if ((state == DONE) && io.res_ready) begin
      if (hit_q) begin
        if (stat_hits != 32'hFFFF_FFFF) stat_hits <= stat_hits + 32'd1;
      end else begin
        if (stat_misses != 32'hFFFF_FFFF) stat_misses <= stat_misses + 32'd1;
      end
    end
  end
`else
  assign stat_hits   = '0;
  assign stat_misses = '0;
`endif
endmodule

// File: tb/tb_pkt_classifier_linear.sv
// Scoreboard bench for pkt_classifier_linear: expected results are queued on
// packet accept and compared (hit, index, latency) when res_valid appears.
module tb_pkt_classifier_linear;
  localparam int NR = 16;
  localparam logic [103:0] ALL1 = '1;

  typedef struct {
    logic       hit;
    logic [3:0] idx;
    int         lat;
    int         t_acc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        busy;
  logic [31:0] stat_hits, stat_misses;
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;
  exp_t        sb[$];

  pkt_classifier_linear_if #(.IDX_W(4)) bus();

  pkt_classifier_linear #(.NUM_RULES(NR), .IDX_W(4)) dut (
    .clk(clk), .rst(rst), .io(bus), .busy(busy),
    .stat_hits(stat_hits), .stat_misses(stat_misses)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, cyc=%0d", cyc);
    $fatal(1);
  end

  function automatic logic [103:0] mk(input logic [31:0] s, input logic [31:0] d,
                                      input logic [15:0] sp, input logic [15:0] dp,
                                      input logic [7:0] pr);
    return {s, d, sp, dp, pr};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_rule(input logic [3:0] idx, input logic [103:0] lo,
                         input logic [103:0] hi, input logic en);
    bus.rule_wr_en = 1'b1; bus.rule_wr_idx = idx;
    bus.rule_wr_lo = lo;   bus.rule_wr_hi = hi; bus.rule_wr_enable = en;
    tick();
    bus.rule_wr_en = 1'b0;
  endtask

  // Offer one header from IDLE; the accept edge is the next one.
  task automatic send(input logic [103:0] d, input logic eh, input logic [3:0] ei,
                      input int el);
    exp_t e;
    bus.pkt_valid = 1'b1; bus.pkt_data = d;
    e.hit = eh; e.idx = ei; e.lat = el; e.t_acc = cyc + 1;
    sb.push_back(e);
    tick();
    bus.pkt_valid = 1'b0;
  endtask

  // Returns observed result fields and the edge after which res_valid was seen.
  task automatic wait_res(input bit ack, output logic h, output logic [3:0] i,
                          output int m, output bit to);
    to = 1'b1;
    for (int n = 0; n < 60; n++) begin
      if (bus.res_valid === 1'b1) begin to = 1'b0; break; end
      tick();
    end
    h = bus.res_hit; i = bus.res_rule_idx; m = cyc;
    if (ack && !to) begin
      bus.res_ready = 1'b1;
      tick();
      bus.res_ready = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    checks++;
    if ({bus.res_valid, bus.res_hit, bus.res_rule_idx, busy} !== 7'b0) begin
      errors++;
      $display("FAIL reset_outputs: got valid=%b hit=%b idx=%0d busy=%b, want all 0",
               bus.res_valid, bus.res_hit, bus.res_rule_idx, busy);
    end
    checks++;
    if ({bus.pkt_ready, bus.rule_wr_ready} !== 2'b11) begin
      errors++;
      $display("FAIL reset_ready: got pkt_ready=%b wr_ready=%b, want 1 1",
               bus.pkt_ready, bus.rule_wr_ready);
    end
    checks++;
    if (stat_hits !== 32'd0 || stat_misses !== 32'd0) begin
      errors++;
      $display("FAIL reset_stats: got hits=%0d misses=%0d, want 0 0", stat_hits, stat_misses);
    end
  endtask

  task automatic test_miss_empty();
    logic h; logic [3:0] i; int m; bit to; exp_t e;
    send(mk(32'h0A00_0001, 32'd0, 16'd0, 16'd0, 8'd0), 1'b0, 4'd0, 17);
    wait_res(1'b1, h, i, m, to);
    e = sb.pop_front();
    checks++;
    if (to || h !== e.hit || i !== e.idx || (m + 1 - e.t_acc) != e.lat) begin
      errors++;
      $display("FAIL miss_empty: got to=%0b hit=%b idx=%0d lat=%0d, want hit=%b idx=%0d lat=%0d",
               to, h, i, m + 1 - e.t_acc, e.hit, e.idx, e.lat);
    end
  endtask

  task automatic test_priority();
    logic h; logic [3:0] i; int m; bit to; exp_t e;
    logic [103:0] hx;
    hx = mk(32'h0A00_0001, 32'hC0A8_0001, 16'd1234, 16'd80, 8'd6);
    wr_rule(4'd3, '0, ALL1, 1'b1);
    wr_rule(4'd7, hx, hx, 1'b1);
    for (int n = 0; n < 2; n++) begin
      if (n == 1) wr_rule(4'd3, '0, ALL1, 1'b0);
      send(hx, 1'b1, (n == 0) ? 4'd3 : 4'd7, (n == 0) ? 5 : 9);
      wait_res(1'b1, h, i, m, to);
      e = sb.pop_front();
      checks++;
      if (to || h !== e.hit || i !== e.idx || (m + 1 - e.t_acc) != e.lat) begin
        errors++;
        $display("FAIL priority_%0d: got to=%0b hit=%b idx=%0d lat=%0d, want hit=%b idx=%0d lat=%0d",
                 n, to, h, i, m + 1 - e.t_acc, e.hit, e.idx, e.lat);
      end
    end
  endtask

  // proto exact-range on entry 2, then inverted and normal dst_port ranges on entry 1.
  task automatic test_ranges();
    logic h; logic [3:0] i; int m; bit to; exp_t e;
    logic [7:0]  pr [8]  = '{8'd17, 8'd6, 8'd18, 8'd6, 8'd6, 8'd6, 8'd6, 8'd6};
    logic [15:0] dp [8]  = '{16'd2000, 16'd2000, 16'd2000, 16'd75, 16'd50, 16'd100, 16'd49, 16'd101};
    logic        eh [8]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    logic [3:0]  ei [8]  = '{4'd2, 4'd0, 4'd0, 4'd0, 4'd1, 4'd1, 4'd0, 4'd0};
    int          el [8]  = '{4, 17, 17, 17, 3, 3, 17, 17};
    wr_rule(4'd2, mk(32'd0, 32'd0, 16'd0, 16'd0, 8'd17), mk('1, '1, '1, '1, 8'd17), 1'b1);
    wr_rule(4'd1, mk(32'd0, 32'd0, 16'd0, 16'd100, 8'd0), mk('1, '1, '1, 16'd50, '1), 1'b1);
    for (int n = 0; n < 8; n++) begin
      if (n == 4)
        wr_rule(4'd1, mk(32'd0, 32'd0, 16'd0, 16'd50, 8'd0), mk('1, '1, '1, 16'd100, '1), 1'b1);
      send(mk(32'h0102_0304, 32'h0506_0708, 16'd1000, dp[n], pr[n]), eh[n], ei[n], el[n]);
      wait_res(1'b1, h, i, m, to);
      e = sb.pop_front();
      checks++;
      if (to || h !== e.hit || i !== e.idx || (m + 1 - e.t_acc) != e.lat) begin
        errors++;
        $display("FAIL ranges_%0d: got to=%0b hit=%b idx=%0d lat=%0d, want hit=%b idx=%0d lat=%0d",
                 n, to, h, i, m + 1 - e.t_acc, e.hit, e.idx, e.lat);
      end
    end
  endtask

  task automatic test_stall();
    logic h; logic [3:0] i; int m; bit to; exp_t e;
    logic [103:0] hd;
    hd = mk(32'h0102_0304, 32'h0506_0708, 16'd1000, 16'd2000, 8'd17);
    send(hd, 1'b1, 4'd2, 4);
    wait_res(1'b0, h, i, m, to);
    e = sb.pop_front();
    checks++;
    if (to || h !== e.hit || i !== e.idx || (m + 1 - e.t_acc) != e.lat) begin
      errors++;
      $display("FAIL stall_first: got to=%0b hit=%b idx=%0d lat=%0d, want hit=%b idx=%0d lat=%0d",
               to, h, i, m + 1 - e.t_acc, e.hit, e.idx, e.lat);
    end
    // Try to disable entry 2 while the result is held; it must be ignored.
    bus.rule_wr_en = 1'b1; bus.rule_wr_idx = 4'd2; bus.rule_wr_enable = 1'b0;
    bus.rule_wr_lo = '0; bus.rule_wr_hi = '0;
    for (int n = 0; n < 10; n++) begin
      tick();
      checks++;
      if ({bus.res_valid, bus.res_hit, bus.res_rule_idx, bus.pkt_ready, bus.rule_wr_ready, busy}
          !== {1'b1, 1'b1, 4'd2, 1'b0, 1'b0, 1'b1}) begin
        errors++;
        $display("FAIL stall_hold_%0d: got valid=%b hit=%b idx=%0d pkt_ready=%b wr_ready=%b, want 1 1 2 0 0",
                 n, bus.res_valid, bus.res_hit, bus.res_rule_idx, bus.pkt_ready, bus.rule_wr_ready);
      end
    end
    bus.rule_wr_en = 1'b0;
    bus.res_ready = 1'b1; bus.pkt_valid = 1'b1; bus.pkt_data = hd;
    tick();
    bus.res_ready = 1'b0;
    checks++;
    if ({bus.pkt_ready, bus.res_valid, busy} !== 3'b100) begin
      errors++;
      $display("FAIL stall_idle: got pkt_ready=%b valid=%b busy=%b, want 1 0 0",
               bus.pkt_ready, bus.res_valid, busy);
    end
    e.hit = 1'b1; e.idx = 4'd2; e.lat = 4; e.t_acc = cyc + 1;
    sb.push_back(e);
    tick();
    bus.pkt_valid = 1'b0;
    wait_res(1'b1, h, i, m, to);
    e = sb.pop_front();
    checks++;
    if (to || h !== e.hit || i !== e.idx || (m + 1 - e.t_acc) != e.lat) begin
      errors++;
      $display("FAIL stall_next: got to=%0b hit=%b idx=%0d lat=%0d, want hit=%b idx=%0d lat=%0d",
               to, h, i, m + 1 - e.t_acc, e.hit, e.idx, e.lat);
    end
  endtask

  task automatic test_same_cycle();
    logic h; logic [3:0] i; int m; bit to; exp_t e;
    bus.rule_wr_en = 1'b1; bus.rule_wr_idx = 4'd0; bus.rule_wr_enable = 1'b1;
    bus.rule_wr_lo = '0; bus.rule_wr_hi = ALL1;
    send(mk(32'h0909_0909, 32'd1, 16'd2, 16'd3, 8'd6), 1'b1, 4'd0, 2);
    bus.rule_wr_en = 1'b0;
    wait_res(1'b1, h, i, m, to);
    e = sb.pop_front();
    checks++;
    if (to || h !== e.hit || i !== e.idx || (m + 1 - e.t_acc) != e.lat) begin
      errors++;
      $display("FAIL same_cycle: got to=%0b hit=%b idx=%0d lat=%0d, want hit=%b idx=%0d lat=%0d",
               to, h, i, m + 1 - e.t_acc, e.hit, e.idx, e.lat);
    end
  endtask

  task automatic test_rst_mid_scan();
    logic h; logic [3:0] i; int m; bit to; exp_t e; bit seen;
    wr_rule(4'd0, '0, ALL1, 1'b0);
    bus.pkt_valid = 1'b1;
    bus.pkt_data = mk(32'h0909_0909, 32'd1, 16'd2, 16'd2000, 8'd6);
    tick();
    bus.pkt_valid = 1'b0;
    repeat (3) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if ({bus.pkt_ready, busy, bus.res_valid} !== 3'b100) begin
      errors++;
      $display("FAIL rst_scan_idle: got pkt_ready=%b busy=%b valid=%b, want 1 0 0",
               bus.pkt_ready, busy, bus.res_valid);
    end
    seen = 1'b0;
    for (int n = 0; n < 20; n++) begin
      if (bus.res_valid !== 1'b0) seen = 1'b1;
      tick();
    end
    checks++;
    if (seen) begin
      errors++;
      $display("FAIL rst_scan_no_result: got res_valid=1 after reset, want 0");
    end
    // Headers that matched entries 7 and 2 before reset must now miss.
    for (int n = 0; n < 2; n++) begin
      send((n == 0) ? mk(32'h0A00_0001, 32'hC0A8_0001, 16'd1234, 16'd80, 8'd6)
                    : mk(32'h0102_0304, 32'h0506_0708, 16'd1000, 16'd2000, 8'd17),
           1'b0, 4'd0, 17);
      wait_res(1'b1, h, i, m, to);
      e = sb.pop_front();
      checks++;
      if (to || h !== e.hit || i !== e.idx || (m + 1 - e.t_acc) != e.lat) begin
        errors++;
        $display("FAIL rst_cleared_%0d: got to=%0b hit=%b idx=%0d lat=%0d, want hit=%b idx=%0d lat=%0d",
                 n, to, h, i, m + 1 - e.t_acc, e.hit, e.idx, e.lat);
      end
    end
  endtask

  task automatic test_stats();
    logic h; logic [3:0] i; int m; bit to; exp_t e;
    logic [31:0] xh, xm;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    wr_rule(4'd0, mk(32'd0, 32'd0, 16'd0, 16'd0, 8'd17), mk('1, '1, '1, '1, 8'd17), 1'b1);
    for (int n = 0; n < 5; n++) begin
      send(mk(32'h1, 32'h2, 16'd3, 16'd4, (n < 3) ? 8'd17 : 8'd6),
           (n < 3) ? 1'b1 : 1'b0, 4'd0, (n < 3) ? 2 : 17);
      wait_res(1'b1, h, i, m, to);
      e = sb.pop_front();
      checks++;
      if (to || h !== e.hit || i !== e.idx || (m + 1 - e.t_acc) != e.lat) begin
        errors++;
        $display("FAIL stats_pkt_%0d: got to=%0b hit=%b idx=%0d lat=%0d, want hit=%b idx=%0d lat=%0d",
                 n, to, h, i, m + 1 - e.t_acc, e.hit, e.idx, e.lat);
      end
    end
`ifdef CLASSIFIER_STATS_EN
    xh = 32'd3; xm = 32'd2;
`else
    xh = 32'd0; xm = 32'd0;
`endif
    checks++;
    if (stat_hits !== xh || stat_misses !== xm) begin
      errors++;
      $display("FAIL stats_count: got hits=%0d misses=%0d, want hits=%0d misses=%0d",
               stat_hits, stat_misses, xh, xm);
    end
  endtask

  initial begin
    bus.rule_wr_en = 1'b0; bus.rule_wr_idx = '0; bus.rule_wr_lo = '0;
    bus.rule_wr_hi = '0;   bus.rule_wr_enable = 1'b0;
    bus.pkt_valid = 1'b0;  bus.pkt_data = '0; bus.res_ready = 1'b0;
    test_reset();
    test_miss_empty();
    test_priority();
    test_ranges();
    test_stall();
    test_same_cycle();
    test_rst_mid_scan();
    test_stats();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
